// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MIPS ID/EX stage.
//   ALU control codes, ALUOp encodings, R-type funct codes and the
//   two-state stage enum used by id_ex_stage.
package mips_pkg;

  // ALU control codes driven on ctl
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  // ALUOp encodings from the main decoder
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_ORI = 2'b11;

  // R-type funct field values
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} stage_state_t;

endpackage

// File: rtl/alu_ctl_dec.sv
// alu_ctl_dec: combinational ALUOp/funct -> ALU control decoder.
//   alu_op  in  2  ALUOp from the main decoder
//   funct   in  6  R-type function field
//   ctl     out 4  ALU control code
//   illegal out 1  R-type funct not supported (ctl forced to ALU_ILL)
import mips_pkg::*;

module alu_ctl_dec (
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] ctl,
  output logic       illegal
);

  always_comb begin
    ctl     = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_MEM: ctl = ALU_ADD;
      ALUOP_BR:  ctl = ALU_SUB;
      ALUOP_ORI: ctl = ALU_OR;
      default: begin
        case (funct)
          FN_ADD:  ctl = ALU_ADD;
          FN_SUB:  ctl = ALU_SUB;
          FN_AND:  ctl = ALU_AND;
          FN_OR:   ctl = ALU_OR;
          FN_SLT:  ctl = ALU_SLT;
          default: begin
            ctl     = ALU_ILL;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
//   Decodes ALU control, resolves operands (optional EX/MEM and MEM/WB
//   forwarding), extends the immediate and holds the result behind a
//   valid/ready handshake. Optional feature macro: ID_EX_FWD_EN
//   (forwarding on capture plus writeback snooping while stalled).
// Ports:
//   clk, rst_n (sync, active low), flush
//   in_valid/in_ready, alu_op, funct, alu_src, reg_dst,
//   rs_addr, rt_addr, rd_addr, rs_data, rt_data, imm
//   exmem_wr/exmem_rd/exmem_res, memwb_wr/memwb_rd/memwb_res
//   out_valid/out_ready, ctl, a, b, store_data, wr_addr, illegal
import mips_pkg::*;

module id_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             alu_src,
  input  logic             reg_dst,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  input  logic [4:0]       rd_addr,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [15:0]      imm,
  input  logic             exmem_wr,
  input  logic [4:0]       exmem_rd,
  input  logic [WIDTH-1:0] exmem_res,
  input  logic             memwb_wr,
  input  logic [4:0]       memwb_rd,
  input  logic [WIDTH-1:0] memwb_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       ctl,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] store_data,
  output logic [4:0]       wr_addr,
  output logic             illegal
);

  stage_state_t     state;
  logic [3:0]       ctl_q;
  logic [WIDTH-1:0] a_q, b_q, sd_q;
  logic [4:0]       wr_q, rs_q, rt_q;
  logic             ill_q;
  logic             b_is_rt;   // b came from rt, so it must follow snoops

  logic [3:0]       dec_ctl;
  logic             dec_ill;
  logic [WIDTH-1:0] ext_imm, fwd_rs, fwd_rt;
  logic             cap;

  alu_ctl_dec u_dec (
    .alu_op  (alu_op),
    .funct   (funct),
    .ctl     (dec_ctl),
    .illegal (dec_ill)
  );

  // Same priority for capture-time forwarding and hold snooping:
  // EX/MEM over MEM/WB, register 0 never forwarded.
  function automatic logic [WIDTH-1:0] fwd(input logic [4:0] addr,
                                           input logic [WIDTH-1:0] base);
    logic [WIDTH-1:0] r;
    r = base;
`ifdef ID_EX_FWD_EN
    if (addr != 5'd0 && exmem_wr && exmem_rd == addr)      r = exmem_res;
    else if (addr != 5'd0 && memwb_wr && memwb_rd == addr) r = memwb_res;
`else
    if (addr == 5'h1f) r = base;   // forwarding disabled: identity
`endif
    return r;
  endfunction

`ifndef ID_EX_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{exmem_wr, exmem_rd, exmem_res,
                        memwb_wr, memwb_rd, memwb_res};
`endif

  assign ext_imm = (alu_op == ALUOP_ORI) ? {{(WIDTH-16){1'b0}}, imm}
                                         : {{(WIDTH-16){imm[15]}}, imm};
  assign fwd_rs  = fwd(rs_addr, rs_data);
  assign fwd_rt  = fwd(rt_addr, rt_data);

  assign out_valid  = (state == ST_FULL);
  assign in_ready   = !out_valid || out_ready;
  assign cap        = in_valid && in_ready;

  assign ctl        = ctl_q;
  assign a          = a_q;
  assign b          = b_q;
  assign store_data = sd_q;
  assign wr_addr    = wr_q;
  assign illegal    = ill_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      ctl_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sd_q    <= '0;
      wr_q    <= '0;
      ill_q   <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      b_is_rt <= 1'b0;
    end else if (flush) begin
      state <= ST_EMPTY;         // discarded beat is not replayed
    end else if (cap) begin
      state   <= ST_FULL;
      ctl_q   <= dec_ctl;
      ill_q   <= dec_ill;
      a_q     <= fwd_rs;
      b_q     <= alu_src ? ext_imm : fwd_rt;
      sd_q    <= fwd_rt;
      wr_q    <= reg_dst ? rd_addr : rt_addr;
      rs_q    <= rs_addr;
      rt_q    <= rt_addr;
      b_is_rt <= !alu_src;
    end else begin
      case (state)
        ST_FULL: begin
          if (out_ready) begin
            state <= ST_EMPTY;
          end else begin
            // stalled: keep held operands coherent with writebacks
            a_q  <= fwd(rs_q, a_q);
            sd_q <= fwd(rt_q, sd_q);
            if (b_is_rt) b_q <= fwd(rt_q, b_q);
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic        alu_src, reg_dst;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rs_data, rt_data;
  logic [15:0] imm;
  logic        exmem_wr, memwb_wr;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_res, memwb_res;
  logic        out_valid, out_ready;
  logic [3:0]  ctl;
  logic [31:0] a, b, store_data;
  logic [4:0]  wr_addr;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .alu_src(alu_src), .reg_dst(reg_dst),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_res(memwb_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctl(ctl), .a(a), .b(b), .store_data(store_data),
    .wr_addr(wr_addr), .illegal(illegal)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one held instruction record ----------
  typedef struct {
    bit          vld;
    logic [3:0]  ctl;
    bit          ill;
    logic [31:0] a, b, sd;
    logic [4:0]  wr, rs, rt;
    bit          b_reg;
  } instr_t;

  instr_t m = '{vld: 0, ctl: 0, ill: 0, a: 0, b: 0, sd: 0, wr: 0, rs: 0, rt: 0, b_reg: 0};

  // {illegal, ctl} straight from the decode table
  function automatic logic [4:0] mdec(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 5'b0_0010;
    if (op == 2'b01) return 5'b0_0110;
    if (op == 2'b11) return 5'b0_0001;
    case (f)
      6'b100000: return 5'b0_0010;
      6'b100010: return 5'b0_0110;
      6'b100100: return 5'b0_0000;
      6'b100101: return 5'b0_0001;
      6'b101010: return 5'b0_0111;
      default:   return 5'b1_1111;
    endcase
  endfunction

  // value a reader of register r would see this cycle, starting from v
  function automatic logic [31:0] mval(input logic [4:0] r, input logic [31:0] v);
    if (!FWD || r == 0) return v;
    if (exmem_wr && exmem_rd == r) return exmem_res;
    if (memwb_wr && memwb_rd == r) return memwb_res;
    return v;
  endfunction

  always @(posedge clk) begin
    logic [4:0] d;
    bit accept;
    started = 1;
    if (!rst_n) begin
      m = '{vld: 0, ctl: 0, ill: 0, a: 0, b: 0, sd: 0, wr: 0, rs: 0, rt: 0, b_reg: 0};
    end else begin
      accept = in_valid && (!m.vld || out_ready);
      if (flush) m.vld = 0;
      else if (accept) begin
        d       = mdec(alu_op, funct);
        m.vld   = 1;
        m.ctl   = d[3:0];
        m.ill   = d[4];
        m.a     = mval(rs_addr, rs_data);
        m.sd    = mval(rt_addr, rt_data);
        m.b     = alu_src ? (alu_op == 2'b11 ? {16'h0, imm} : {{16{imm[15]}}, imm}) : m.sd;
        m.wr    = reg_dst ? rd_addr : rt_addr;
        m.rs    = rs_addr;
        m.rt    = rt_addr;
        m.b_reg = !alu_src;
      end else if (m.vld && out_ready) m.vld = 0;
      else if (m.vld) begin
        m.a  = mval(m.rs, m.a);
        m.sd = mval(m.rt, m.sd);
        if (m.b_reg) m.b = mval(m.rt, m.b);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, m.vld});
      chk("in_ready", {31'b0, in_ready}, {31'b0, (!m.vld || out_ready)});
      if (m.vld) begin
        chk("ctl", {28'b0, ctl}, {28'b0, m.ctl});
        chk("illegal", {31'b0, illegal}, {31'b0, m.ill});
        chk("a", a, m.a);
        chk("b", b, m.b);
        chk("store_data", store_data, m.sd);
        chk("wr_addr", {27'b0, wr_addr}, {27'b0, m.wr});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [1:0] op, input logic [5:0] f, input logic src,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] im);
    in_valid = 1; alu_op = op; funct = f; alu_src = src; reg_dst = 1;
    rs_addr = rs; rt_addr = rt; rd_addr = rd; rs_data = rsd; rt_data = rtd; imm = im;
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; alu_op = 0; funct = 0; alu_src = 0; reg_dst = 0;
    rs_addr = 0; rt_addr = 0; rd_addr = 0; rs_data = 0; rt_data = 0; imm = 0;
    exmem_wr = 0; exmem_rd = 0; exmem_res = 0; memwb_wr = 0; memwb_rd = 0; memwb_res = 0;
    out_ready = 1;
    repeat (2) step();
    @(negedge clk);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst ctl", {28'b0, ctl}, 32'd0);
    chk("rst a", a, 32'd0);
    chk("rst b", b, 32'd0);
    chk("rst store_data", store_data, 32'd0);
    chk("rst wr_addr", {27'b0, wr_addr}, 32'd0);
    chk("rst illegal", {31'b0, illegal}, 32'd0);
    rst_n = 1;

    // R-type SUB
    instr(2'b10, 6'b100010, 0, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 16'h0);
    step(); in_valid = 0;
    @(negedge clk);
    chk("sub valid", {31'b0, out_valid}, 32'd1);
    chk("sub ctl", {28'b0, ctl}, 32'h6);
    chk("sub a", a, 32'd10);
    chk("sub b", b, 32'd3);
    chk("sub wr", {27'b0, wr_addr}, 32'd3);

    // forward priority EX/MEM over MEM/WB
    instr(2'b10, 6'b100000, 0, 5'd5, 5'd9, 5'd4, 32'h11, 32'h12, 16'h0);
    exmem_wr = 1; exmem_rd = 5; exmem_res = 32'hAA;
    memwb_wr = 1; memwb_rd = 5; memwb_res = 32'hBB;
    step();
    @(negedge clk);
    chk("fwd exmem", a, FWD ? 32'hAA : 32'h11);
    // MEM/WB only
    instr(2'b10, 6'b100101, 0, 5'd6, 5'd9, 5'd4, 32'h21, 32'h22, 16'h0);
    exmem_rd = 5; memwb_rd = 6;
    step();
    @(negedge clk);
    chk("fwd memwb", a, FWD ? 32'hBB : 32'h21);
    chk("or ctl", {28'b0, ctl}, 32'h1);
    // register 0 never forwarded
    instr(2'b10, 6'b100100, 0, 5'd0, 5'd9, 5'd4, 32'h33, 32'h34, 16'h0);
    exmem_rd = 0; memwb_rd = 0;
    step();
    exmem_wr = 0; memwb_wr = 0;
    @(negedge clk);
    chk("r0 no fwd", a, 32'h33);

    // ori zero-extends, load/store sign-extends, branch subtracts
    instr(2'b11, 6'b000000, 1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'hFFFF);
    step();
    @(negedge clk);
    chk("ori b", b, 32'h0000FFFF);
    chk("ori ctl", {28'b0, ctl}, 32'h1);
    instr(2'b00, 6'b000000, 1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'hFFFF);
    step();
    @(negedge clk);
    chk("addi b", b, 32'hFFFFFFFF);
    chk("addi ctl", {28'b0, ctl}, 32'h2);
    instr(2'b01, 6'b000000, 0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0);
    step();
    instr(2'b10, 6'b101010, 0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0);
    step(); in_valid = 0;
    @(negedge clk);
    chk("slt ctl", {28'b0, ctl}, 32'h7);

    // stall with snoop on rt=7
    instr(2'b10, 6'b100000, 0, 5'd1, 5'd7, 5'd8, 32'h1, 32'h10, 16'h0);
    step();
    out_ready = 0;
    instr(2'b10, 6'b100000, 0, 5'd2, 5'd3, 5'd4, 32'h99, 32'h98, 16'h0);
    step();
    step();
    memwb_wr = 1; memwb_rd = 7; memwb_res = 32'h55;
    step();
    memwb_wr = 0;
    @(negedge clk);
    chk("snoop b", b, FWD ? 32'h55 : 32'h10);
    chk("snoop sd", store_data, FWD ? 32'h55 : 32'h10);
    chk("stall in_ready", {31'b0, in_ready}, 32'd0);
    exmem_wr = 1; exmem_rd = 7; exmem_res = 32'h66;
    memwb_wr = 1; memwb_rd = 7; memwb_res = 32'h77;
    step();
    exmem_wr = 0; memwb_wr = 0;
    @(negedge clk);
    chk("snoop prio", b, FWD ? 32'h66 : 32'h10);
    out_ready = 1;
    step(); in_valid = 0;
    @(negedge clk);
    chk("b2b a", a, 32'h99);

    // flush beats concurrent illegal capture
    instr(2'b10, 6'b000111, 0, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 16'h0);
    flush = 1;
    step();
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush valid", {31'b0, out_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("flush no replay", {31'b0, out_valid}, 32'd0);

    // illegal funct captured normally
    instr(2'b10, 6'b000111, 0, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 16'h0);
    step(); in_valid = 0;
    @(negedge clk);
    chk("illegal", {31'b0, illegal}, 32'd1);
    chk("illegal ctl", {28'b0, ctl}, 32'hF);

    // flush while stalled
    instr(2'b10, 6'b100000, 0, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 16'h0);
    out_ready = 0;
    step(); in_valid = 0;
    step();
    flush = 1;
    step();
    flush = 0; out_ready = 1;
    @(negedge clk);
    chk("flush stall", {31'b0, out_valid}, 32'd0);

    // reset mid-stall
    instr(2'b10, 6'b100000, 0, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 16'h0);
    step(); in_valid = 0; out_ready = 0;
    step();
    rst_n = 0;
    step();
    rst_n = 1; out_ready = 1;
    @(negedge clk);
    chk("rst stall valid", {31'b0, out_valid}, 32'd0);
    chk("rst stall a", a, 32'd0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
